// File: rtl/and_arb_pkg.sv
// Shared constants and helpers for the shared AND-datapath arbiter.
// Imported by the picker and the top level.
package and_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 8;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/and_share_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or above ptr,
// wrapping around, wins.
module rr_pick
  import and_arb_pkg::*;
#(
  parameter int N    = N_REQ_DEF,
  parameter int ID_W = id_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    // Walk from the farthest offset down so the nearest one wins.
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = ID_W'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/and_share_arbiter.sv
// N requesters share one 2-stage registered AND datapath through a
// round-robin arbiter; results return with the requester ID.
module and_share_arbiter
  import and_arb_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  parameter  int WIDTH = WIDTH_DEF,
  localparam int ID_W  = id_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  input  logic                   rsp_ready
);

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } s1_t;

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  ptr_nxt;
  logic [ID_W-1:0]  gnt_idx;
  logic [N_REQ-1:0] gnt;
  logic             gnt_any;
  logic             s1_valid;
  logic             s1_adv;
  logic             s2_adv;
  logic             xfer;
  s1_t              s1;
  s1_t              s1_in;

  assign s2_adv = !rsp_valid || rsp_ready;
  assign s1_adv = !s1_valid || s2_adv;

  rr_pick #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  // Gating with rst_n keeps req_ready low while reset is held.
  assign xfer      = rst_n && s1_adv && gnt_any;
  assign req_ready = xfer ? gnt : '0;

  assign s1_in.id = gnt_idx;
  assign s1_in.a  = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
  assign s1_in.b  = req_b[int'(gnt_idx)*WIDTH +: WIDTH];

  assign ptr_nxt = (int'(gnt_idx) == N_REQ - 1) ? '0
                 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
      ptr      <= '0;
    end else begin
      if (s1_adv) s1_valid <= xfer;
      if (xfer) begin
        s1  <= s1_in;
        ptr <= ptr_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      if (s2_adv) rsp_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        rsp_id   <= s1.id;
        rsp_data <= s1.a & s1.b;
      end
    end
  end

endmodule

// File: tb/tb_and_share_arbiter.sv
// Bench for and_share_arbiter: FIFO-level reference model with per-cycle
// compare, plus directed scenarios with literal expectations.
module tb_and_share_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  rv;
  logic [31:0] ra, rb;
  logic [3:0]  rr;
  logic        ov;
  logic [1:0]  oid;
  logic [7:0]  od;
  logic        ordy;

  logic        rv1;
  logic [15:0] ra1, rb1;
  logic        rr1;
  logic        ov1;
  logic        oid1;
  logic [15:0] od1;
  logic        ordy1;

  and_share_arbiter #(.N_REQ(4), .WIDTH(8)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (rv),
    .req_a     (ra),
    .req_b     (rb),
    .req_ready (rr),
    .rsp_valid (ov),
    .rsp_id    (oid),
    .rsp_data  (od),
    .rsp_ready (ordy)
  );

  and_share_arbiter #(.N_REQ(1), .WIDTH(16)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (rv1),
    .req_a     (ra1),
    .req_b     (rb1),
    .req_ready (rr1),
    .rsp_valid (ov1),
    .rsp_id    (oid1),
    .rsp_data  (od1),
    .rsp_ready (ordy1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each transfer is a FIFO entry stamped with the edge it
  // entered on; the head is visible one edge later and at most two entries
  // may be outstanding unless the head is leaving this cycle.
  typedef struct {
    int          id;
    logic [15:0] d;
    int          t;
  } item_t;

  item_t q4[$];
  item_t q1[$];
  int    p4 = 0;
  int    p1 = 0;
  int    ecnt = 0;

  function automatic int pick(input int n, input logic [3:0] v, input int p);
    for (int k = 0; k < n; k++) begin
      if (v[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_rdy4();
    int g;
    if (!rst_n) return 4'b0;
    if (!(q4.size() < 2 || ordy)) return 4'b0;
    g = pick(4, rv, p4);
    if (g < 0) return 4'b0;
    return 4'(1 << g);
  endfunction

  function automatic logic exp_rdy1();
    if (!rst_n) return 1'b0;
    return rv1 && (q1.size() < 2 || ordy1);
  endfunction

  function automatic logic vis4();
    return q4.size() > 0 && q4[0].t < ecnt;
  endfunction

  function automatic logic vis1();
    return q1.size() > 0 && q1[0].t < ecnt;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q4.delete();
        q1.delete();
        p4 = 0;
        p1 = 0;
      end else begin
        logic [3:0] g4;
        logic       g1;
        logic       c4, c1;
        int         gi;
        g4 = exp_rdy4();
        g1 = exp_rdy1();
        c4 = vis4() && ordy;
        c1 = vis1() && ordy1;
        if (c4) void'(q4.pop_front());
        if (c1) void'(q1.pop_front());
        if (g4 != 0) begin
          gi = pick(4, rv, p4);
          q4.push_back('{gi, 16'(ra[gi*8 +: 8] & rb[gi*8 +: 8]), ecnt + 1});
          p4 = (gi + 1) % 4;
        end
        if (g1) q1.push_back('{0, ra1 & rb1, ecnt + 1});
        ecnt++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("rdy4", 32'(rr), 32'(exp_rdy4()));
      chk("vld4", 32'(ov), 32'(vis4()));
      if (vis4()) begin
        chk("id4", 32'(oid), 32'(q4[0].id));
        chk("dat4", 32'(od), 32'(q4[0].d));
      end
      chk("rdy1", 32'(rr1), 32'(exp_rdy1()));
      chk("vld1", 32'(ov1), 32'(vis1()));
      if (vis1()) begin
        chk("id1", 32'(oid1), 32'(q1[0].id));
        chk("dat1", 32'(od1), 32'(q1[0].d));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  int          n;
  int          xfers;
  int          cons;
  logic [7:0]  dat[16];
  logic [1:0]  ids[16];
  logic [15:0] a1[4], b1[4], e1[4];
  logic [7:0]  hold_d;
  logic [1:0]  hold_id;
  logic [1:0]  ptr_exp[4];
  logic [3:0]  gnt_exp[4];

  initial begin
    rst_n = 1'b0;
    rv = 4'hF; ra = '0; rb = '0; ordy = 1'b1;
    rv1 = 1'b0; ra1 = '0; rb1 = '0; ordy1 = 1'b1;
    #1;
    chk("rst_rdy", 32'(rr), 32'h0);
    chk("rst_vld", 32'(ov), 32'h0);
    chk("rst_id", 32'(oid), 32'h0);
    chk("rst_dat", 32'(od), 32'h0);
    #11 rst_n = 1'b1;
    rv = 4'h0;

    // Single requester
    step();
    rv = 4'b0100; ra[23:16] = 8'hF0; rb[23:16] = 8'h3C;
    #1 chk("t1_rdy", 32'(rr), 32'h4);
    step();
    rv = 4'b0;
    chk("t1_lat1", 32'(ov), 32'h0);
    step();
    chk("t1_vld", 32'(ov), 32'h1);
    chk("t1_id", 32'(oid), 32'h2);
    chk("t1_dat", 32'(od), 32'h30);
    step();
    chk("t1_once", 32'(ov), 32'h0);

    // Full fairness
    pulse_reset();
    ra = 32'hFFFF_FFFF;
    rb = {8'd4, 8'd3, 8'd2, 8'd1};
    rv = 4'hF;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) rv = 4'h0;
      #1;
      if (i < 8) chk("t2_gnt", 32'(rr), 32'(1 << (i % 4)));
      step();
      if (ov) begin
        dat[n] = od; ids[n] = oid; n++;
      end
    end
    chk("t2_count", 32'(n), 32'd8);
    for (int j = 0; j < 8; j++) begin
      chk("t2_dat", 32'(dat[j]), 32'((j % 4) + 1));
      chk("t2_id", 32'(ids[j]), 32'(j % 4));
    end

    // Sparse wrap-around, starting from ptr=2
    pulse_reset();
    ra = 32'h1234_5678; rb = 32'hFFFF_FFFF;
    rv = 4'b0010;
    step();
    chk("t3_ptr0", 32'(dut4.ptr), 32'h2);
    rv = 4'b1010;
    gnt_exp[0] = 4'b1000; gnt_exp[1] = 4'b0010;
    gnt_exp[2] = 4'b1000; gnt_exp[3] = 4'b0010;
    ptr_exp[0] = 2'd0; ptr_exp[1] = 2'd2;
    ptr_exp[2] = 2'd0; ptr_exp[3] = 2'd2;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t3_gnt", 32'(rr), 32'(gnt_exp[i]));
      step();
      chk("t3_ptr", 32'(dut4.ptr), 32'(ptr_exp[i]));
    end
    rv = 4'b0;
    step();
    step();

    // Backpressure
    pulse_reset();
    ordy = 1'b0;
    rv = 4'hF;
    ra = 32'hC3A5_5AF0; rb = 32'h7E0F_F00F;
    xfers = 0;
    cons = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (rr != 0) xfers++;
      step();
      if (i == 2) begin
        hold_d = od; hold_id = oid;
      end
      if (i > 2) begin
        chk("t4_hold_d", 32'(od), 32'(hold_d));
        chk("t4_hold_id", 32'(oid), 32'(hold_id));
      end
    end
    chk("t4_xfers", 32'(xfers), 32'd2);
    chk("t4_stall_rdy", 32'(rr), 32'h0);
    chk("t4_hold_vld", 32'(ov), 32'h1);
    ordy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) rv = 4'h0;
      #1;
      if (rr != 0) xfers++;
      if (ov) cons++;
      step();
    end
    chk("t4_drain", 32'(cons), 32'(xfers));

    // Async reset with both stages full
    ordy = 1'b0;
    rv = 4'hF;
    step();
    step();
    chk("t5_full", 32'(ov), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_vld", 32'(ov), 32'h0);
    chk("t5_rst_rdy", 32'(rr), 32'h0);
    chk("t5_rst_dat", 32'(od), 32'h0);
    rv = 4'b0110;
    ordy = 1'b1;
    rst_n = 1'b1;
    #1 chk("t5_first", 32'(rr), 32'h2);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) rv = 4'h0;
      step();
      if (ov) begin
        ids[n] = oid; n++;
      end
    end
    chk("t5_count", 32'(n), 32'd2);
    chk("t5_id0", 32'(ids[0]), 32'd1);
    chk("t5_id1", 32'(ids[1]), 32'd2);

    // Single-requester instance, back to back
    a1[0] = 16'hAAAA; b1[0] = 16'h0FF0; e1[0] = 16'h0AA0;
    a1[1] = 16'h1234; b1[1] = 16'hFF00; e1[1] = 16'h1200;
    a1[2] = 16'hFFFF; b1[2] = 16'h8001; e1[2] = 16'h8001;
    a1[3] = 16'h0F0F; b1[3] = 16'hFFFF; e1[3] = 16'h0F0F;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin
        rv1 = 1'b1; ra1 = a1[i]; rb1 = b1[i];
        #1 chk("t6_rdy", 32'(rr1), 32'h1);
      end else begin
        rv1 = 1'b0;
      end
      step();
      if (ov1) begin
        if (n < 4) begin
          chk("t6_dat", 32'(od1), 32'(e1[n]));
          chk("t6_id", 32'(oid1), 32'h0);
        end
        n++;
      end
    end
    chk("t6_count", 32'(n), 32'd4);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
